// File: rtl/drm_bridge_pkg.sv
// ----------------------------------------------------------------------------
// drm_bridge_pkg
//   Shared definitions for the DRM user-IP stream bridge.
//   - Downstream word layout (controller -> activator): [0] dat, [1] we,
//     [3:2] adr, [4] cyc, [5] cs, [31:6] reserved (must be zero).
//   - Upstream word layout (activator -> controller): {28'd0, ack, intr, sta, dat}.
//   - Upstream output-register state enum and a packing helper.
// ----------------------------------------------------------------------------
package drm_bridge_pkg;

    // Bit positions inside the downstream word.
    localparam int DAT_B   = 0;
    localparam int WE_B    = 1;
    localparam int ADR_LSB = 2;
    localparam int CYC_B   = 4;
    localparam int CS_B    = 5;

    // Any bit set under this mask marks a malformed downstream word.
    localparam logic [31:0] RSVD_MASK = 32'hFFFF_FFC0;

    // Activator-facing bus fields, ordered to match bits [5:0] of the word.
    typedef struct packed {
        logic       cs;
        logic       cyc;
        logic [1:0] adr;
        logic       we;
        logic       dat;
    } drm_act_bus_t;

    typedef struct packed {
        logic [25:0]  rsvd;
        drm_act_bus_t bus;
    } drm_down_word_t;

    typedef struct packed {
        logic [27:0] rsvd;
        logic        ack;
        logic        intr;
        logic        sta;
        logic        dat;
    } drm_up_word_t;

    // Upstream output register: empty, or holding a word offered to the controller.
    typedef enum logic {
        UP_IDLE = 1'b0,
        UP_SEND = 1'b1
    } up_state_t;

    function automatic drm_up_word_t pack_up(input logic ack, input logic intr,
                                             input logic sta, input logic dat);
        drm_up_word_t w;
        w      = '0;
        w.ack  = ack;
        w.intr = intr;
        w.sta  = sta;
        w.dat  = dat;
        return w;
    endfunction

endpackage

// File: rtl/drm_bridge_watchdog.sv
// ----------------------------------------------------------------------------
// drm_bridge_watchdog
//   Link watchdog for the controller stream. The counter clears on every valid
//   cycle, otherwise counts up and saturates at TIMEOUT_CYCLES; timeout_o is
//   high while the counter sits at that limit. A valid in the expiry cycle
//   wins, so the timeout never asserts on that edge.
// Ports
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   valid_i    in   controller word valid this cycle
//   timeout_o  out  watchdog expired
// ----------------------------------------------------------------------------
module drm_bridge_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic clk,
    input  logic rst_n,
    input  logic valid_i,
    output logic timeout_o
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (valid_i) begin
            cnt_d = '0;
        end else if (cnt_q != LIMIT) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign timeout_o = (cnt_q == LIMIT);

endmodule

// File: rtl/drm_uip_stream_bridge.sv
// ----------------------------------------------------------------------------
// drm_uip_stream_bridge
//   User-IP endpoint of the DRM controller stream link.
//   Downstream: each accepted 32-bit word is decoded into the activator bus
//   (cyc/we/adr/dat/cs) one cycle later; the decode holds between words.
//   A word with any reserved bit set raises the sticky proto_err.
//   Upstream: the activator return signals form a pending word that is sent
//   whenever it differs from the last word sent, or when the refresh counter
//   expires. The output register obeys AXI4-Stream hold rules; under
//   backpressure intermediate values may be dropped, the latest wins.
//   Watchdog: when the controller stream stops for TIMEOUT_CYCLES, act_cyc and
//   act_cs are forced low until the next valid word.
// Configuration
//   DRM_BRIDGE_INPUT_SYNC_EN : when defined, activator inputs pass a 2-flop
//   synchronizer before forming the pending word (input->m_drm_tvalid 3
//   cycles); otherwise they are used directly (1 cycle).
// Ports
//   drm_aclk, drm_arstn                   clock / async active-low reset
//   s_drm_tvalid/tready/tdata             controller -> bridge stream
//   m_drm_tvalid/tready/tdata             bridge -> controller stream
//   act_cyc/act_we/act_adr/act_dat/act_cs decoded activator bus
//   act_dat_o/act_sta/act_intr/act_ack    activator return signals
//   link_timeout                          watchdog expired
//   proto_err                             sticky reserved-bit violation
// ----------------------------------------------------------------------------
module drm_uip_stream_bridge
    import drm_bridge_pkg::*;
#(
    parameter int unsigned REFRESH_CYCLES = 1024,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic        drm_aclk,
    input  logic        drm_arstn,
    input  logic        s_drm_tvalid,
    output logic        s_drm_tready,
    input  logic [31:0] s_drm_tdata,
    output logic        m_drm_tvalid,
    input  logic        m_drm_tready,
    output logic [31:0] m_drm_tdata,
    output logic        act_cyc,
    output logic        act_we,
    output logic [1:0]  act_adr,
    output logic        act_dat,
    output logic        act_cs,
    input  logic        act_dat_o,
    input  logic        act_sta,
    input  logic        act_intr,
    input  logic        act_ack,
    output logic        link_timeout,
    output logic        proto_err
);

    localparam int unsigned RW = $clog2(REFRESH_CYCLES);
    localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_CYCLES - 1);

    // ------------------------------------------------------------------
    // Downstream decode
    // ------------------------------------------------------------------
    logic         tready_q;
    logic         accept;
    logic         rsvd_hit;
    drm_act_bus_t dec_d;
    drm_act_bus_t bus_q;
    logic         proto_q;

    assign accept   = s_drm_tvalid && tready_q;
    assign rsvd_hit = (s_drm_tdata & RSVD_MASK) != '0;

    // NOTE: every variable written in an always_comb gets a default first,
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        dec_d     = '0;
        dec_d.dat = s_drm_tdata[DAT_B];
        dec_d.we  = s_drm_tdata[WE_B];
        dec_d.adr = s_drm_tdata[ADR_LSB +: 2];
        dec_d.cyc = s_drm_tdata[CYC_B];
        dec_d.cs  = s_drm_tdata[CS_B];
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value regardless of statement order.
    always_ff @(posedge drm_aclk or negedge drm_arstn) begin
        if (!drm_arstn) begin
            tready_q <= 1'b0;
            bus_q    <= '0;
            proto_q  <= 1'b0;
        end else begin
            tready_q <= 1'b1;
            if (accept) begin
                bus_q <= dec_d;
                // Fields are still decoded from a malformed word.
                if (rsvd_hit) begin
                    proto_q <= 1'b1;
                end
            end
        end
    end

    assign s_drm_tready = tready_q;
    assign proto_err    = proto_q;

    // ------------------------------------------------------------------
    // Link watchdog
    // ------------------------------------------------------------------
    logic timeout;

    drm_bridge_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk      (drm_aclk),
        .rst_n    (drm_arstn),
        .valid_i  (s_drm_tvalid),
        .timeout_o(timeout)
    );

    assign link_timeout = timeout;

    // Only the bus-cycle qualifiers are forced idle; the decode register
    // keeps its contents so the bus resumes cleanly on the next word.
    assign act_cyc = bus_q.cyc & ~timeout;
    assign act_cs  = bus_q.cs  & ~timeout;
    assign act_we  = bus_q.we;
    assign act_adr = bus_q.adr;
    assign act_dat = bus_q.dat;

    // ------------------------------------------------------------------
    // Upstream pending word
    // ------------------------------------------------------------------
    drm_up_word_t pend_w;

`ifdef DRM_BRIDGE_INPUT_SYNC_EN
    logic [3:0] sync1_q;
    logic [3:0] sync2_q;

    always_ff @(posedge drm_aclk or negedge drm_arstn) begin
        if (!drm_arstn) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= {act_ack, act_intr, act_sta, act_dat_o};
            sync2_q <= sync1_q;
        end
    end

    assign pend_w = pack_up(sync2_q[3], sync2_q[2], sync2_q[1], sync2_q[0]);
`else
    assign pend_w = pack_up(act_ack, act_intr, act_sta, act_dat_o);
`endif

    // ------------------------------------------------------------------
    // Upstream output register
    // ------------------------------------------------------------------
    up_state_t    state_q;
    up_state_t    state_d;
    drm_up_word_t data_q;
    drm_up_word_t data_d;
    drm_up_word_t last_q;
    drm_up_word_t last_d;
    logic [RW-1:0] refresh_q;
    logic [RW-1:0] refresh_d;
    logic          send;
    logic          load;

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        last_d    = last_q;
        refresh_d = (refresh_q == REFRESH_LAST) ? refresh_q : refresh_q + RW'(1);

        send = (pend_w != last_q) || (refresh_q == REFRESH_LAST);
        // A new word may replace the current one only once it is accepted
        // (or the register is empty); this keeps tdata stable under stall.
        load = send && ((state_q == UP_IDLE) || m_drm_tready);

        if (load) begin
            state_d   = UP_SEND;
            data_d    = pend_w;
            last_d    = pend_w;
            refresh_d = '0;
        end else if ((state_q == UP_SEND) && m_drm_tready) begin
            state_d = UP_IDLE;
        end
    end

    always_ff @(posedge drm_aclk or negedge drm_arstn) begin
        if (!drm_arstn) begin
            state_q   <= UP_IDLE;
            data_q    <= '0;
            last_q    <= '0;
            refresh_q <= '0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            last_q    <= last_d;
            refresh_q <= refresh_d;
        end
    end

    assign m_drm_tvalid = (state_q == UP_SEND);
    assign m_drm_tdata  = data_q;

endmodule
